// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480@60 raster and the 12-bit pixel layout.
// Also holds the colour-bar lookup used when VGA_TEST_PATTERN_EN is defined.
package vga_timing_pkg;

  localparam int unsigned P_CNT_W = 10;

  localparam int unsigned P_H_VIS   = 640;
  localparam int unsigned P_H_FP    = 16;
  localparam int unsigned P_H_SYNC  = 96;
  localparam int unsigned P_H_BP    = 48;
  localparam int unsigned P_H_TOTAL = P_H_VIS + P_H_FP + P_H_SYNC + P_H_BP;

  localparam int unsigned P_V_VIS   = 480;
  localparam int unsigned P_V_FP    = 10;
  localparam int unsigned P_V_SYNC  = 2;
  localparam int unsigned P_V_BP    = 33;
  localparam int unsigned P_V_TOTAL = P_V_VIS + P_V_FP + P_V_SYNC + P_V_BP;

  localparam int unsigned P_HS_START = P_H_VIS + P_H_FP;
  localparam int unsigned P_HS_END   = P_HS_START + P_H_SYNC - 1;
  localparam int unsigned P_VS_START = P_V_VIS + P_V_FP;
  localparam int unsigned P_VS_END   = P_VS_START + P_V_SYNC - 1;

  // pixel_data layout: [11:8] blue, [7:4] green, [3:0] red
  localparam int unsigned P_PIX_W     = 4;
  localparam int unsigned P_PIX_R_LSB = 0;
  localparam int unsigned P_PIX_G_LSB = 4;
  localparam int unsigned P_PIX_B_LSB = 8;

  localparam int unsigned P_MAX_PIXEL_LAT = 4;
  localparam int unsigned P_BAR_W         = 80;

  // Bars left to right: white, blue, green, red, yellow, magenta, cyan, black.
  // Returned in pixel_data layout {b, g, r}.
  function automatic logic [11:0] bar_colour(input logic [P_CNT_W-1:0] i_x);
    logic [2:0] w_idx;
    logic [11:0] w_col;
    w_idx = 3'(i_x / 10'(P_BAR_W));
    case (w_idx)
      3'd0:    w_col = 12'hfff;
      3'd1:    w_col = 12'hf00;
      3'd2:    w_col = 12'h0f0;
      3'd3:    w_col = 12'h00f;
      3'd4:    w_col = 12'h0ff;
      3'd5:    w_col = 12'hf0f;
      3'd6:    w_col = 12'hff0;
      default: w_col = 12'h000;
    endcase
    return w_col;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Link between the timing controller (master) and the page renderer / pins (slave).
// pattern_sel only exists when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_ctrl_if;

  logic [11:0] pixel_data;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic        video_on;
  logic        frame_start;
  logic        hs;
  logic        vs;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
`ifdef VGA_TEST_PATTERN_EN
  logic        pattern_sel;
`endif

  modport master (
`ifdef VGA_TEST_PATTERN_EN
    input  pattern_sel,
`endif
    input  pixel_data,
    output x_pos, y_pos, video_on, frame_start,
    output hs, vs, vga_r, vga_g, vga_b
  );

  modport slave (
`ifdef VGA_TEST_PATTERN_EN
    output pattern_sel,
`endif
    output pixel_data,
    input  x_pos, y_pos, video_on, frame_start,
    input  hs, vs, vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/vga_timing_ctrl_delay_line.sv
// Fixed-depth register delay line with a per-instance reset value.
// DEPTH of 0 is a straight wire.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = i_clk ^ i_rst_n;
      assign o_q = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= RST_VAL;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster counters, position decode and latency-matched sync/RGB pin registers.
// Optional macro VGA_TEST_PATTERN_EN adds pattern_sel and an 8-bar colour generator.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned PIXEL_LAT = 1,
  parameter int unsigned H_VIS     = P_H_VIS,
  parameter int unsigned H_FP      = P_H_FP,
  parameter int unsigned H_SYNC    = P_H_SYNC,
  parameter int unsigned H_BP      = P_H_BP,
  parameter int unsigned V_VIS     = P_V_VIS,
  parameter int unsigned V_FP      = P_V_FP,
  parameter int unsigned V_SYNC    = P_V_SYNC,
  parameter int unsigned V_BP      = P_V_BP
) (
  input  logic              vga_clk,
  input  logic              vga_rst_n,
  vga_timing_ctrl_if.master bus
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [P_CNT_W-1:0] L_H_LAST   = P_CNT_W'(H_TOTAL - 1);
  localparam logic [P_CNT_W-1:0] L_V_LAST   = P_CNT_W'(V_TOTAL - 1);
  localparam logic [P_CNT_W-1:0] L_H_VIS    = P_CNT_W'(H_VIS);
  localparam logic [P_CNT_W-1:0] L_V_VIS    = P_CNT_W'(V_VIS);
  localparam logic [P_CNT_W-1:0] L_HS_START = P_CNT_W'(H_VIS + H_FP);
  localparam logic [P_CNT_W-1:0] L_HS_END   = P_CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [P_CNT_W-1:0] L_VS_START = P_CNT_W'(V_VIS + V_FP);
  localparam logic [P_CNT_W-1:0] L_VS_END   = P_CNT_W'(V_VIS + V_FP + V_SYNC - 1);

  generate
    if (PIXEL_LAT > P_MAX_PIXEL_LAT) begin : g_bad_lat
      $error("vga_timing_ctrl: PIXEL_LAT must be in 0..4");
    end
  endgenerate

  logic [P_CNT_W-1:0] r_h_cnt;
  logic [P_CNT_W-1:0] r_v_cnt;

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == L_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == L_V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  logic               w_video_on;
  logic               w_hs_raw;
  logic               w_vs_raw;
  logic [P_CNT_W-1:0] w_x_pos;

  assign w_video_on = (r_h_cnt < L_H_VIS) && (r_v_cnt < L_V_VIS);
  assign w_hs_raw   = !((r_h_cnt >= L_HS_START) && (r_h_cnt <= L_HS_END));
  assign w_vs_raw   = !((r_v_cnt >= L_VS_START) && (r_v_cnt <= L_VS_END));
  assign w_x_pos    = w_video_on ? r_h_cnt : '0;

  assign bus.x_pos       = w_x_pos;
  assign bus.y_pos       = w_video_on ? r_v_cnt : '0;
  assign bus.video_on    = w_video_on;
  assign bus.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

  // Sync idles high and blanking idles low while the line refills after reset.
  logic [2:0] w_ctl_dly;
  logic       w_hs_dly;
  logic       w_vs_dly;
  logic       w_de_dly;

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIXEL_LAT),
    .RST_VAL (3'b110)
  ) u_ctl_dly (
    .i_clk   (vga_clk),
    .i_rst_n (vga_rst_n),
    .i_d     ({w_hs_raw, w_vs_raw, w_video_on}),
    .o_q     (w_ctl_dly)
  );

  assign {w_hs_dly, w_vs_dly, w_de_dly} = w_ctl_dly;

  logic [11:0] w_pix;

`ifdef VGA_TEST_PATTERN_EN
  logic [P_CNT_W-1:0] w_x_dly;

  vga_delay_line #(
    .WIDTH   (P_CNT_W),
    .DEPTH   (PIXEL_LAT),
    .RST_VAL ('0)
  ) u_x_dly (
    .i_clk   (vga_clk),
    .i_rst_n (vga_rst_n),
    .i_d     (w_x_pos),
    .o_q     (w_x_dly)
  );

  assign w_pix = bus.pattern_sel ? bar_colour(w_x_dly) : bus.pixel_data;
`else
  assign w_pix = bus.pixel_data;
`endif

  logic        r_hs;
  logic        r_vs;
  logic [11:0] r_rgb;

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_rgb <= '0;
    end else begin
      r_hs  <= w_hs_dly;
      r_vs  <= w_vs_dly;
      r_rgb <= w_de_dly ? w_pix : '0;
    end
  end

  assign bus.hs    = r_hs;
  assign bus.vs    = r_vs;
  assign bus.vga_r = r_rgb[P_PIX_R_LSB +: P_PIX_W];
  assign bus.vga_g = r_rgb[P_PIX_G_LSB +: P_PIX_W];
  assign bus.vga_b = r_rgb[P_PIX_B_LSB +: P_PIX_W];

endmodule
